mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/tiny16_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 25 ++
 rtl/mem_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/tiny16_pkg.sv
// Shared FSM encoding and requester indices for the two-port memory arbiter.
package tiny16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way winner select: round-robin against the last grant, or requester 0 first.
// Purely combinational; callers sample the result only while idle.
module rr_arbiter2
  import tiny16_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_vld,
  output logic gnt_idx
);

  always_comb begin
    gnt_vld = req0 | req1;
    gnt_idx = REQ0;
    if (req0 && req1) begin
      gnt_idx = (FIXED_PRIO != 0) ? REQ0 : ~last_gnt;
    end else if (req1) begin
      gnt_idx = REQ1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one MAR-style memory: IDLE->ADDR->DATA->RESP, ack 3 cycles after grant.
// Losers hold req and wait; the winning request is latched in IDLE so later input changes are ignored.
module mem_arbiter
  import tiny16_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic        r0_we,
  input  logic        r1_we,
  input  logic [15:0] r0_addr,
  input  logic [15:0] r1_addr,
  input  logic [15:0] r0_wdata,
  input  logic [15:0] r1_wdata,
  output logic        r0_ack,
  output logic        r1_ack,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        mem_addr_en,
  output logic [15:0] mem_addr,
  output logic        mem_in_en,
  output logic [15:0] mem_in,
  output logic        mem_out_en,
  input  logic [15:0] mem_out
);

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        win_vld, win_idx;

  rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .req0     (r0_req),
    .req1     (r1_req),
    .last_gnt (last_q),
    .gnt_vld  (win_vld),
    .gnt_idx  (win_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = ADDR;
          gnt_d   = win_idx;
          we_d    = (win_idx == REQ1) ? r1_we    : r0_we;
          addr_d  = (win_idx == REQ1) ? r1_addr  : r0_addr;
          wdata_d = (win_idx == REQ1) ? r1_wdata : r0_wdata;
        end
      end
      ADDR: state_d = DATA;
      DATA: begin
        if (!we_q) rdata_d = mem_out;
        state_d = RESP;
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= REQ0;
      last_q  <= REQ1;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes are gated by rst directly so a write in flight never lands during reset.
  assign mem_addr_en = !rst && (state_q == ADDR);
  assign mem_in_en   = !rst && (state_q == DATA) && we_q;
  assign mem_out_en  = !rst && (state_q == DATA) && !we_q;
  assign mem_addr    = addr_q;
  assign mem_in      = wdata_q;

  assign r0_ack = (state_q == RESP) && (gnt_q == REQ0);
  assign r1_ack = (state_q == RESP) && (gnt_q == REQ1);
  assign busy   = (state_q != IDLE);
  assign rdata  = rdata_q;

endmodule
